// File: rtl/quad_position_ctrl.sv
// ---------------------------------------------------------------------------
// quad_position_ctrl
//   Quadrature encoder position controller. The raw A/B phases and the index
//   pulse pass through a 2-flop synchronizer and a per-signal glitch filter.
//   The filtered A/B pair is Gray-decoded into forward, reverse or illegal
//   steps, and these steps drive a wrapping position counter. The counter
//   can also be cleared, preset by a load, or zeroed by the index pulse.
//
// Parameters
//   WIDTH       position counter width in bits
//   FILT        consecutive equal samples needed to accept a change (1..15)
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   a_in, b_in  raw quadrature phases (asynchronous)
//   idx_in      raw index pulse (asynchronous)
//   idx_en      enables zeroing of position on a filtered index rising edge
//   clear       synchronous position clear (highest priority)
//   load        synchronous preset of position to load_value
//   load_value  preset value
//   cmp_value   compare target for cmp_hit
//   err_clr     clears the sticky error flag
//   position    two's-complement position count
//   dir         direction of the last accepted step (1 = forward)
//   step_pulse  one-cycle pulse per accepted step
//   cmp_hit     one-cycle pulse after position changes to cmp_value
//   err_flag    sticky illegal-transition flag
// ---------------------------------------------------------------------------
module quad_position_ctrl #(
    parameter int WIDTH = 16,
    parameter int FILT  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             idx_in,
    input  logic             idx_en,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] cmp_value,
    input  logic             err_clr,
    output logic [WIDTH-1:0] position,
    output logic             dir,
    output logic             step_pulse,
    output logic             cmp_hit,
    output logic             err_flag
);

    localparam logic [3:0]       CNT_LAST = 4'(FILT - 1);
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    // Bit order for all three-signal vectors: {idx, a, b}
    logic [2:0]       sync1_q, sync2_q;
    logic [2:0]       filt_q;
    logic [3:0]       cnt_q [3];

    logic [1:0]       ab_q;
    logic             idx_prev_q;
    logic             fwd_d, rev_d, ill_d;
    logic             fwd_q, rev_q, ill_q, idx_rise_q;

    logic [WIDTH-1:0] position_d, position_q;
    logic             dir_d, dir_q;
    logic             err_d, err_q;
    logic             step_q, chg_q, cmp_hit_q;

    // Synchronizers and glitch filters. A filter only moves after FILT
    // consecutive samples disagree with it; one agreeing sample restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            filt_q  <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= {idx_in, a_in, b_in};
            sync2_q <= sync1_q;
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    filt_q[i] <= sync2_q[i];
                    cnt_q[i]  <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 4'd1;
                end
            end
        end
    end

    // Gray decode of previous vs. current filtered {A,B}.
    // Forward order is 00 -> 01 -> 11 -> 10 -> 00.
    always_comb begin
        fwd_d = 1'b0;
        rev_d = 1'b0;
        ill_d = 1'b0;
        case ({ab_q, filt_q[1:0]})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: fwd_d = 1'b1;
            4'b0010, 4'b1011, 4'b1101, 4'b0100: rev_d = 1'b1;
            4'b0011, 4'b1100, 4'b0110, 4'b1001: ill_d = 1'b1;
            default: ;
        endcase
    end

    // Decode stage: the state register always follows the filtered value,
    // including after an illegal transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ab_q       <= '0;
            idx_prev_q <= 1'b0;
            fwd_q      <= 1'b0;
            rev_q      <= 1'b0;
            ill_q      <= 1'b0;
            idx_rise_q <= 1'b0;
        end else begin
            ab_q       <= filt_q[1:0];
            idx_prev_q <= filt_q[2];
            fwd_q      <= fwd_d;
            rev_q      <= rev_d;
            ill_q      <= ill_d;
            idx_rise_q <= filt_q[2] & ~idx_prev_q;
        end
    end

    // Position priority: clear, load, index, step. A discarded step still
    // shows up on step_pulse and dir. A new illegal event beats err_clr.
    always_comb begin
        position_d = position_q;
        if (clear) begin
            position_d = '0;
        end else if (load) begin
            position_d = load_value;
        end else if (idx_rise_q && idx_en) begin
            position_d = '0;
        end else if (fwd_q) begin
            position_d = position_q + ONE;
        end else if (rev_q) begin
            position_d = position_q - ONE;
        end

        dir_d = dir_q;
        if (fwd_q) begin
            dir_d = 1'b1;
        end else if (rev_q) begin
            dir_d = 1'b0;
        end

        err_d = err_q;
        if (ill_q) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    // Output registers. cmp_hit looks at the value the position register
    // took on the previous edge, and only if that edge actually changed it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            position_q <= '0;
            dir_q      <= 1'b0;
            step_q     <= 1'b0;
            err_q      <= 1'b0;
            chg_q      <= 1'b0;
            cmp_hit_q  <= 1'b0;
        end else begin
            position_q <= position_d;
            dir_q      <= dir_d;
            step_q     <= fwd_q | rev_q;
            err_q      <= err_d;
            chg_q      <= (position_d != position_q);
            cmp_hit_q  <= chg_q && (position_q == cmp_value);
        end
    end

    assign position   = position_q;
    assign dir        = dir_q;
    assign step_pulse = step_q;
    assign cmp_hit    = cmp_hit_q;
    assign err_flag   = err_q;

endmodule

// File: tb/tb_quad_position_ctrl.sv
// ---------------------------------------------------------------------------
// tb_quad_position_ctrl
//   Self-checking bench for quad_position_ctrl. A behavioural model tracks
//   each raw input through a two-cycle delay and a run-length filter, turns
//   filtered phase moves into signed quarter-turn deltas, and applies them
//   two cycles later. A compare process checks the DUT against that model on
//   every clock after reset; directed sections add literal expectations.
// ---------------------------------------------------------------------------
module tb_quad_position_ctrl;

    localparam int WIDTH = 16;
    localparam int FILT  = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             a_in = 1'b0, b_in = 1'b0, idx_in = 1'b0, idx_en = 1'b0;
    logic             clear = 1'b0, load = 1'b0, err_clr = 1'b0;
    logic [WIDTH-1:0] load_value = '0, cmp_value = '0;
    logic [WIDTH-1:0] position;
    logic             dir, step_pulse, cmp_hit, err_flag;

    int checks = 0;
    int failures = 0;
    int stepCount = 0;
    int hitCount = 0;
    bit compareOn = 1'b0;

    always #5 clk = ~clk;

    quad_position_ctrl #(.WIDTH(WIDTH), .FILT(FILT)) dut (
        .clk        (clk),
        .rst        (rst),
        .a_in       (a_in),
        .b_in       (b_in),
        .idx_in     (idx_in),
        .idx_en     (idx_en),
        .clear      (clear),
        .load       (load),
        .load_value (load_value),
        .cmp_value  (cmp_value),
        .err_clr    (err_clr),
        .position   (position),
        .dir        (dir),
        .step_pulse (step_pulse),
        .cmp_hit    (cmp_hit),
        .err_flag   (err_flag)
    );

    // Quarter-turn index of a Gray phase pair along the forward direction
    function automatic int grayIdx(input logic [1:0] g);
        case (g)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    logic [1:0] grayOf [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    typedef struct packed {
        bit fwd;
        bit rev;
        bit ill;
        bit idxRise;
    } ev_t;

    logic [WIDTH-1:0] mPos;
    bit               mDir, mStep, mHit, mErr, mChg;
    bit               mFilt [3];
    int               mRun [3];
    ev_t              evQ [$];
    logic [2:0]       rawHist [$];

    // Reference model: inputs reach the filters two edges late, a filter
    // flips after FILT disagreeing samples in a row, and a decoded event is
    // applied to the outputs two edges after the filter accepted it.
    always @(posedge clk or posedge rst) begin
        logic [2:0]       seen;
        logic [2:0]       oldF;
        logic [WIDTH-1:0] newPos;
        ev_t              ev;
        ev_t              nev;
        int               delta;
        if (rst) begin
            mPos = '0;
            mDir = 0; mStep = 0; mHit = 0; mErr = 0; mChg = 0;
            for (int i = 0; i < 3; i++) begin
                mFilt[i] = 0;
                mRun[i]  = 0;
            end
            rawHist.delete();
            rawHist.push_back(3'b000);
            rawHist.push_back(3'b000);
            evQ.delete();
            evQ.push_back('0);
            evQ.push_back('0);
        end else begin
            seen = rawHist.pop_front();
            rawHist.push_back({idx_in, a_in, b_in});

            ev   = evQ.pop_front();
            mHit = mChg && (mPos == cmp_value);
            if (clear)                      newPos = '0;
            else if (load)                  newPos = load_value;
            else if (ev.idxRise && idx_en)  newPos = '0;
            else if (ev.fwd)                newPos = mPos + WIDTH'(1);
            else if (ev.rev)                newPos = mPos - WIDTH'(1);
            else                            newPos = mPos;
            mChg  = (newPos != mPos);
            mPos  = newPos;
            mStep = ev.fwd || ev.rev;
            if (ev.fwd)      mDir = 1;
            else if (ev.rev) mDir = 0;
            if (ev.ill)          mErr = 1;
            else if (err_clr)    mErr = 0;

            oldF = {mFilt[2], mFilt[1], mFilt[0]};
            for (int i = 0; i < 3; i++) begin
                if (seen[i] == mFilt[i]) begin
                    mRun[i] = 0;
                end else begin
                    mRun[i]++;
                    if (mRun[i] == FILT) begin
                        mFilt[i] = seen[i];
                        mRun[i]  = 0;
                    end
                end
            end
            delta = (grayIdx({mFilt[1], mFilt[0]}) - grayIdx(oldF[1:0]) + 4) % 4;
            nev = '0;
            nev.fwd     = (delta == 1);
            nev.rev     = (delta == 3);
            nev.ill     = (delta == 2);
            nev.idxRise = mFilt[2] && !oldF[2];
            evQ.push_back(nev);
        end
    end

    // Cycle-by-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (compareOn && !rst) begin
            checks++;
            if ({position, dir, step_pulse, cmp_hit, err_flag} !==
                {mPos, mDir, mStep, mHit, mErr}) begin
                failures++;
                $display("[TB] FAIL model_compare t=%0t actual pos=%h dir=%b step=%b hit=%b err=%b required pos=%h dir=%b step=%b hit=%b err=%b",
                         $time, position, dir, step_pulse, cmp_hit, err_flag,
                         mPos, mDir, mStep, mHit, mErr);
            end
            if (step_pulse) stepCount++;
            if (cmp_hit)    hitCount++;
        end
    end

    // Advance n clocks, landing 2 time units after the last rising edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [1:0] ab, input int hold);
        {a_in, b_in} = ab;
        tick(hold);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    initial begin
        int r, gi, holdLeft, s0, h0;

        tick(3);
        checkOutput("reset_position", position, 0);
        checkOutput("reset_flags", {dir, step_pulse, cmp_hit, err_flag}, 0);
        rst = 1'b0;
        compareOn = 1'b1;
        tick(5);

        // Four forward steps from 00, with first-update latency pinned
        s0 = stepCount;
        {a_in, b_in} = 2'b01;
        tick(6);
        checkOutput("latency_before_edge6", {15'd0, step_pulse, position}, 0);
        tick(1);
        checkOutput("latency_step_edge6", step_pulse, 1);
        checkOutput("latency_pos_edge6", position, 1);
        tick(3);
        applyStimulus(2'b11, 10);
        applyStimulus(2'b10, 10);
        applyStimulus(2'b00, 10);
        checkOutput("fwd4_position", position, 4);
        checkOutput("fwd4_dir", dir, 1);
        checkOutput("fwd4_pulses", stepCount - s0, 4);

        // Two-cycle glitch on A is rejected
        a_in = 1'b1;
        tick(2);
        a_in = 1'b0;
        tick(10);
        checkOutput("glitch_position", position, 4);
        checkOutput("glitch_pulses", stepCount - s0, 4);

        // Wrap below zero and across the signed boundary
        clear = 1'b1; tick(1); clear = 1'b0; tick(2);
        checkOutput("clear_position", position, 0);
        applyStimulus(2'b10, 10);
        checkOutput("wrap_down_position", position, 32'hFFFF);
        checkOutput("wrap_down_dir", dir, 0);
        load_value = 16'h7FFF; load = 1'b1; tick(1); load = 1'b0;
        applyStimulus(2'b00, 10);
        checkOutput("wrap_up_position", position, 32'h8000);

        // Illegal double-phase change, then clear the sticky flag
        applyStimulus(2'b11, 10);
        checkOutput("illegal_err", err_flag, 1);
        checkOutput("illegal_position", position, 32'h8000);
        err_clr = 1'b1; tick(1); err_clr = 1'b0; tick(1);
        checkOutput("err_clr", err_flag, 0);
        applyStimulus(2'b00, 10);
        checkOutput("illegal_again_err", err_flag, 1);
        err_clr = 1'b1; tick(1); err_clr = 1'b0; tick(1);

        // Compare hit when counting 3 -> 4 -> 5 -> 6
        cmp_value = 16'd5;
        load_value = 16'd3; load = 1'b1; tick(1); load = 1'b0; tick(3);
        h0 = hitCount;
        applyStimulus(2'b01, 10);
        {a_in, b_in} = 2'b11;
        tick(7);
        checkOutput("cmp_reach5_position", position, 5);
        checkOutput("cmp_hit_not_yet", cmp_hit, 0);
        tick(1);
        checkOutput("cmp_hit_pulse", cmp_hit, 1);
        tick(1);
        checkOutput("cmp_hit_one_cycle", cmp_hit, 0);
        tick(7);
        applyStimulus(2'b10, 10);
        checkOutput("cmp_single_hit", hitCount - h0, 1);

        // Clear coincides with a forward step
        {a_in, b_in} = 2'b00;
        tick(6);
        clear = 1'b1;
        tick(1);
        checkOutput("clear_vs_step_position", position, 0);
        checkOutput("clear_vs_step_pulse", step_pulse, 1);
        clear = 1'b0;
        tick(10);

        // Index zeroing enabled and disabled
        load_value = 16'd100; load = 1'b1; tick(1); load = 1'b0;
        idx_en = 1'b1; idx_in = 1'b1; tick(10); idx_in = 1'b0; tick(10);
        checkOutput("index_enabled", position, 0);
        load = 1'b1; tick(1); load = 1'b0;
        idx_en = 1'b0; idx_in = 1'b1; tick(10); idx_in = 1'b0; tick(10);
        checkOutput("index_disabled", position, 100);

        // Randomized traffic with a reset in the middle
        holdLeft = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                rst = 1'b1;
                tick(2);
                rst = 1'b0;
            end
            if (holdLeft == 0) begin
                r  = $urandom_range(0, 9);
                gi = grayIdx({a_in, b_in});
                if (r < 4)      gi = (gi + 1) % 4;
                else if (r < 8) gi = (gi + 3) % 4;
                else            gi = $urandom_range(0, 3);
                {a_in, b_in} = grayOf[gi];
                holdLeft = $urandom_range(1, 7);
            end
            holdLeft--;
            if ($urandom_range(0, 7) == 0) idx_in = ~idx_in;
            idx_en  = 1'($urandom_range(0, 1));
            clear   = ($urandom_range(0, 63) == 0);
            load    = ($urandom_range(0, 31) == 0);
            load_value = ($urandom_range(0, 1) == 0) ? WIDTH'($urandom) : 16'hFFFE;
            err_clr = ($urandom_range(0, 15) == 0);
            if (c % 40 == 0) cmp_value = mPos + WIDTH'($urandom_range(0, 3));
            tick(1);
        end
        clear = 1'b0; load = 1'b0; err_clr = 1'b0;
        tick(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
